// File: rtl/e203_sim_mon_pkg.sv
// Shared constants and FSM encoding for the e203 simulation commit monitor.
package e203_sim_mon_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_ENDING = 2'd1,
        ST_DONE   = 2'd2,
        ST_TMO    = 2'd3
    } mon_state_e;

    localparam logic [31:0] DEF_TOHOST_PC = 32'h8000_0042;
    localparam int          DEF_END_HITS  = 8;
    localparam int          DEF_STALL_LIM = 127;

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

endpackage

// File: rtl/e203_sim_mon_hitcnt.sv
// Counts how many commit channels retire the tohost PC in the current cycle.
module e203_sim_mon_hitcnt
    import e203_sim_mon_pkg::*;
#(
    parameter int              PC_W      = 32,
    parameter int              NCH       = 1,
    parameter logic [PC_W-1:0] TOHOST_PC = DEF_TOHOST_PC,
    parameter int              HW        = $clog2(NCH + 1)
) (
    input  logic [NCH-1:0]      cmt_vld,
    input  logic [NCH*PC_W-1:0] cmt_pc,
    output logic [HW-1:0]       hits
);

    always_comb begin
        hits = '0;
        for (int k = 0; k < NCH; k++) begin
            if (cmt_vld[k] && (cmt_pc[k*PC_W +: PC_W] == TOHOST_PC))
                hits = hits + HW'(1);
        end
    end

endmodule

// File: rtl/e203_sim_commit_monitor.sv
// End-of-test, watchdog, counters and dump-window monitor for the e203 SoC bench.
// Optional idle/stall detector enabled by defining E203_SIM_MON_STALL_DET_EN.
module e203_sim_commit_monitor
    import e203_sim_mon_pkg::*;
#(
    parameter int              PC_W      = 32,
    parameter int              NCH       = 1,
    parameter int              CNT_W     = 32,
    parameter logic [PC_W-1:0] TOHOST_PC = DEF_TOHOST_PC,
    parameter int              END_HITS  = DEF_END_HITS,
    parameter int              WDOG_BIT  = 20,
    parameter int              STALL_LIM = DEF_STALL_LIM
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NCH-1:0]      cmt_vld,
    input  logic [NCH*PC_W-1:0] cmt_pc,
    input  logic                exu_i_vld,
    input  logic                exu_i_rdy,
    input  logic [63:0]         mcycle64,
    input  logic [63:0]         dump_start,
    input  logic [63:0]         dump_end,
    input  logic [31:0]         x3_val,
    output logic [CNT_W-1:0]    cycle_cnt,
    output logic [CNT_W-1:0]    instr_cnt,
    output logic [CNT_W-1:0]    end_cycle,
    output logic [7:0]          tohost_hits,
    output logic                dump_en,
    output logic                done,
    output logic                pass,
    output logic                timeout,
    output logic                stall_flag
);

    localparam int HW = $clog2(NCH + 1);

    mon_state_e    state, state_nxt;
    logic [HW-1:0] hits;
    logic [7:0]    hits_nxt;
    logic          any_hit, reach, wdog;

    e203_sim_mon_hitcnt #(
        .PC_W      (PC_W),
        .NCH       (NCH),
        .TOHOST_PC (TOHOST_PC),
        .HW        (HW)
    ) u_hitcnt (
        .cmt_vld (cmt_vld),
        .cmt_pc  (cmt_pc),
        .hits    (hits)
    );

    assign any_hit  = (hits != '0);
    assign hits_nxt = sat_add8(tohost_hits, 8'(hits));
    // The end condition looks at the count including this cycle's hits so
    // several channels hitting at once can finish the test in one step.
    assign reach    = (hits_nxt >= 8'(END_HITS));
    assign wdog     = cycle_cnt[WDOG_BIT];

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN: begin
                if (any_hit && reach) state_nxt = ST_DONE;
                else if (wdog)        state_nxt = ST_TMO;
                else if (any_hit)     state_nxt = ST_ENDING;
            end
            ST_ENDING: begin
                if (reach)     state_nxt = ST_DONE;
                else if (wdog) state_nxt = ST_TMO;
            end
            default: state_nxt = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_RUN;
            cycle_cnt   <= '0;
            instr_cnt   <= '0;
            end_cycle   <= '0;
            tohost_hits <= '0;
            dump_en     <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state       <= state_nxt;
            tohost_hits <= hits_nxt;
            if (!(&cycle_cnt))
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (state == ST_RUN && !any_hit && exu_i_vld && exu_i_rdy)
                instr_cnt <= instr_cnt + CNT_W'(1);
            if (state == ST_RUN && (state_nxt == ST_ENDING || state_nxt == ST_DONE))
                end_cycle <= cycle_cnt;
            if (state != ST_DONE && state_nxt == ST_DONE) begin
                done <= 1'b1;
                pass <= (x3_val == 32'd1);
            end
            if (state != ST_TMO && state_nxt == ST_TMO)
                timeout <= 1'b1;
            dump_en <= (mcycle64 >= dump_start) && (mcycle64 <= dump_end);
        end
    end

`ifdef E203_SIM_MON_STALL_DET_EN
    localparam int IW = $clog2(STALL_LIM + 1);

    logic [IW-1:0] idle_cnt, idle_nxt;

    always_comb begin
        idle_nxt = idle_cnt;
        if (state == ST_RUN || state == ST_ENDING) begin
            if (|cmt_vld)           idle_nxt = '0;
            else if (!(&idle_cnt))  idle_nxt = idle_cnt + IW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt   <= '0;
            stall_flag <= 1'b0;
        end else begin
            idle_cnt <= idle_nxt;
            if (idle_nxt == IW'(STALL_LIM))
                stall_flag <= 1'b1;
        end
    end
`else
    assign stall_flag = 1'b0;
`endif

endmodule

// File: tb/tb_e203_sim_commit_monitor.sv
// Directed bench for e203_sim_commit_monitor: end-of-test, watchdog, dump window, stall.
module tb_e203_sim_commit_monitor;

    localparam logic [31:0] TH    = 32'h8000_0042;
    localparam logic [31:0] NOPC  = 32'h8000_0100;
`ifdef E203_SIM_MON_STALL_DET_EN
    localparam logic        STALL_EXP = 1'b1;
`else
    localparam logic        STALL_EXP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        exu_vld, exu_rdy;
    logic [63:0] mcycle, dstart, dend;

    // instance A: NCH=1, default watchdog
    logic        a_rst;
    logic [0:0]  a_vld;
    logic [31:0] a_pc, a_x3;
    logic [31:0] a_cyc, a_instr, a_endc;
    logic [7:0]  a_hits;
    logic        a_dump, a_done, a_pass, a_tmo, a_stall;

    // instance B: NCH=2, watchdog at cycle 64
    logic        b_rst;
    logic [1:0]  b_vld;
    logic [63:0] b_pc;
    logic [31:0] b_x3;
    logic [31:0] b_cyc, b_instr, b_endc;
    logic [7:0]  b_hits;
    logic        b_dump, b_done, b_pass, b_tmo, b_stall;

    int vectors = 0;
    int errs    = 0;
    int cyc     = 0;
    int dump_cnt;

    e203_sim_commit_monitor u_dut_a (
        .clk(clk), .rst(a_rst), .cmt_vld(a_vld), .cmt_pc(a_pc),
        .exu_i_vld(exu_vld), .exu_i_rdy(exu_rdy), .mcycle64(mcycle),
        .dump_start(dstart), .dump_end(dend), .x3_val(a_x3),
        .cycle_cnt(a_cyc), .instr_cnt(a_instr), .end_cycle(a_endc),
        .tohost_hits(a_hits), .dump_en(a_dump), .done(a_done), .pass(a_pass),
        .timeout(a_tmo), .stall_flag(a_stall)
    );

    e203_sim_commit_monitor #(.NCH(2), .WDOG_BIT(6)) u_dut_b (
        .clk(clk), .rst(b_rst), .cmt_vld(b_vld), .cmt_pc(b_pc),
        .exu_i_vld(exu_vld), .exu_i_rdy(exu_rdy), .mcycle64(mcycle),
        .dump_start(dstart), .dump_end(dend), .x3_val(b_x3),
        .cycle_cnt(b_cyc), .instr_cnt(b_instr), .end_cycle(b_endc),
        .tohost_hits(b_hits), .dump_en(b_dump), .done(b_done), .pass(b_pass),
        .timeout(b_tmo), .stall_flag(b_stall)
    );

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        vectors++;
        assert (obs === want) else begin
            errs++;
            $error("FAIL %s: got %0h want %0h", tag, obs, want);
        end
    endtask

    task automatic chk_zero_a(input string tag);
        chk({tag, "_a_cyc"}, 64'(a_cyc), 0);
        chk({tag, "_a_instr"}, 64'(a_instr), 0);
        chk({tag, "_a_endc"}, 64'(a_endc), 0);
        chk({tag, "_a_hits"}, 64'(a_hits), 0);
        chk({tag, "_a_flags"}, 64'({a_dump, a_done, a_pass, a_tmo, a_stall}), 0);
    endtask

    task automatic chk_zero_b(input string tag);
        chk({tag, "_b_cyc"}, 64'(b_cyc), 0);
        chk({tag, "_b_hits"}, 64'(b_hits), 0);
        chk({tag, "_b_flags"}, 64'({b_dump, b_done, b_pass, b_tmo, b_stall}), 0);
    endtask

    task automatic reset_a();
        a_rst = 1'b1;
        step();
        step();
        a_rst = 1'b0;
        cyc = 0;
    endtask

    task automatic reset_b();
        b_rst = 1'b1;
        step();
        step();
        b_rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        a_rst = 1'b1; b_rst = 1'b1;
        a_vld = '0; a_pc = NOPC; a_x3 = 32'd1;
        b_vld = '0; b_pc = {NOPC, NOPC}; b_x3 = 32'd1;
        exu_vld = 1'b0; exu_rdy = 1'b0;
        mcycle = '0; dstart = 64'd0; dend = 64'd100;
        step();
        step();
        chk_zero_a("in_rst");
        chk_zero_b("in_rst");
        a_rst = 1'b0; b_rst = 1'b0; cyc = 0;
        chk_zero_a("post_rst");

        // 1: eight tohost commits at 100..170, x3=1, dump window 10..12
        reset_a();
        dstart = 64'd10; dend = 64'd12; a_x3 = 32'd1; dump_cnt = 0;
        for (int c = 0; c < 171; c++) begin
            a_vld   = 1'((c >= 100) && (c <= 170) && (c % 10 == 0));
            a_pc    = a_vld[0] ? TH : NOPC;
            exu_vld = 1'b1;
            exu_rdy = 1'(c % 2 == 0);
            mcycle  = 64'(c);
            step();
            if (a_dump) dump_cnt++;
            if (cyc == 10)  chk("dump_before", 64'(a_dump), 0);
            if (cyc == 11)  chk("dump_first", 64'(a_dump), 1);
            if (cyc == 101) chk("t1_hits1", 64'(a_hits), 1);
            if (cyc == 101) chk("t1_instr_stop", 64'(a_instr), 50);
            if (cyc == 170) chk("t1_done_early", 64'(a_done), 0);
        end
        chk("t1_cycle", 64'(a_cyc), 171);
        chk("t1_done", 64'(a_done), 1);
        chk("t1_pass", 64'(a_pass), 1);
        chk("t1_endc", 64'(a_endc), 100);
        chk("t1_hits", 64'(a_hits), 8);
        chk("t1_instr", 64'(a_instr), 50);
        chk("t1_tmo", 64'(a_tmo), 0);
        chk("t1_dump_cnt", 64'(dump_cnt), 3);

        // 2: same with x3=5, 12 more hits after DONE, reversed dump window
        reset_a();
        dstart = 64'd12; dend = 64'd10; a_x3 = 32'd5; dump_cnt = 0;
        exu_vld = 1'b0;
        for (int c = 0; c < 192; c++) begin
            a_vld  = 1'(((c >= 100) && (c <= 170) && (c % 10 == 0)) || (c >= 180));
            a_pc   = a_vld[0] ? TH : NOPC;
            mcycle = 64'(c);
            step();
            if (a_dump) dump_cnt++;
            if (cyc == 171) chk("t2_done", 64'(a_done), 1);
            if (cyc == 171) chk("t2_pass", 64'(a_pass), 0);
        end
        chk("t2_hits", 64'(a_hits), 20);
        chk("t2_done_stay", 64'(a_done), 1);
        chk("t2_pass_stay", 64'(a_pass), 0);
        chk("t2_tmo", 64'(a_tmo), 0);
        chk("t2_endc", 64'(a_endc), 100);
        chk("t2_cycle", 64'(a_cyc), 192);
        chk("t2_dump_cnt", 64'(dump_cnt), 0);

        // mid-run reset with the dump window open
        dstart = 64'd0; dend = 64'd1000; a_vld = 1'b0;
        a_rst = 1'b1;
        step();
        chk_zero_a("mid_rst");
        a_rst = 1'b0; cyc = 0;
        chk_zero_a("mid_rst_after");

        // 6: stall detector; a commit at the 126th idle cycle, then 127 idle cycles
        dstart = 64'd1; dend = 64'd0;
        for (int c = 0; c < 254; c++) begin
            a_vld = 1'(c == 126);
            a_pc  = NOPC;
            step();
            if (cyc == 127) chk("t6_no_stall", 64'(a_stall), 0);
            if (cyc == 253) chk("t6_stall_early", 64'(a_stall), 0);
        end
        chk("t6_stall", 64'(a_stall), 64'(STALL_EXP));
        chk("t6_done", 64'(a_done), 0);

        // 3: NCH=2, double hits at 10,12,14,16; non-matching PCs at 11
        reset_b();
        chk_zero_b("b_rst");
        b_x3 = 32'd1;
        for (int c = 0; c < 70; c++) begin
            if (c == 10 || c == 12 || c == 14 || c == 16) begin
                b_vld = 2'b11; b_pc = {TH, TH};
            end else if (c == 11) begin
                b_vld = 2'b11; b_pc = {TH ^ 32'd1, 32'd0};
            end else begin
                b_vld = 2'b00; b_pc = {NOPC, NOPC};
            end
            step();
            if (cyc == 12) chk("t3_hits_after11", 64'(b_hits), 2);
            if (cyc == 16) chk("t3_hits6", 64'(b_hits), 6);
            if (cyc == 16) chk("t3_not_done", 64'(b_done), 0);
            if (cyc == 17) chk("t3_hits8", 64'(b_hits), 8);
            if (cyc == 17) chk("t3_done", 64'(b_done), 1);
            if (cyc == 17) chk("t3_endc", 64'(b_endc), 10);
        end
        chk("t3_tmo_after_done", 64'(b_tmo), 0);
        chk("t3_pass", 64'(b_pass), 1);

        // 4: watchdog at cycle 64, later hit ignored
        reset_b();
        b_vld = 2'b00;
        for (int c = 0; c < 75; c++) begin
            b_vld = (c == 70) ? 2'b01 : 2'b00;
            b_pc  = {NOPC, TH};
            step();
            if (cyc == 64) chk("t4_tmo_early", 64'(b_tmo), 0);
            if (cyc == 65) chk("t4_tmo", 64'(b_tmo), 1);
            if (cyc == 65) chk("t4_cycle", 64'(b_cyc), 65);
        end
        chk("t4_tmo_stay", 64'(b_tmo), 1);
        chk("t4_done", 64'(b_done), 0);
        chk("t4_pass", 64'(b_pass), 0);

        // DONE and watchdog on the same cycle: DONE wins
        reset_b();
        b_x3 = 32'd1;
        for (int c = 0; c < 65; c++) begin
            b_vld = (c >= 61) ? 2'b11 : 2'b00;
            b_pc  = {TH, TH};
            step();
            if (cyc == 64) chk("tie_hits6", 64'(b_hits), 6);
            if (cyc == 64) chk("tie_not_done", 64'(b_done), 0);
        end
        b_vld = 2'b00;
        chk("tie_done", 64'(b_done), 1);
        chk("tie_tmo", 64'(b_tmo), 0);
        chk("tie_pass", 64'(b_pass), 1);
        chk("tie_endc", 64'(b_endc), 61);
        chk("tie_hits", 64'(b_hits), 8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
